// File: rtl/byte_word_packer.sv
// Byte-to-word packer: gathers bytes little-endian into BYTES-wide words behind a registered ready/valid output.
// Optional parity output enabled by defining BYTE_WORD_PACKER_PARITY_EN.
module byte_word_packer #(
  parameter int BYTES = 4,
  parameter int CW    = $clog2(BYTES + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 in_ready,
  input  logic                 in_valid,
  input  logic [7:0]           in_bits,
  input  logic                 in_last,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [8*BYTES-1:0]   out_bits,
  output logic [CW-1:0]        out_count,
  output logic                 out_parity
);

  localparam int CNT_W = $clog2(BYTES);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(BYTES - 1);

  logic [CNT_W-1:0]     r_cnt;
  logic [8*BYTES-1:0]   r_asm;
  logic [8*BYTES-1:0]   r_out_bits;
  logic [CW-1:0]        r_out_count;
  logic                 r_out_valid;

  logic                 w_accept;
  logic                 w_done;
  logic [8*BYTES-1:0]   w_word;

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_done   = w_accept && ((r_cnt == LAST_LANE) || in_last);

  // Lanes below cnt come from the assembly register, lane cnt takes the new byte, lanes above are zero.
  always_comb begin
    // NOTE: assign a full default before the loop so no path leaves w_word unassigned (no latch).
    w_word = '0;
    for (int k = 0; k < BYTES; k++) begin
      if (k < int'(r_cnt)) begin
        w_word[8*k +: 8] = r_asm[8*k +: 8];
      end else if (k == int'(r_cnt)) begin
        w_word[8*k +: 8] = in_bits;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_asm       <= '0;
      r_out_bits  <= '0;
      r_out_count <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_done) begin
        r_cnt       <= '0;
        r_asm       <= '0;
        r_out_bits  <= w_word;
        r_out_count <= CW'(r_cnt) + CW'(1);
        r_out_valid <= 1'b1;
      end else begin
        if (w_accept) begin
          r_cnt <= r_cnt + CNT_W'(1);
          r_asm <= w_word;
        end
        if (out_ready) begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_bits  = r_out_bits;
  assign out_count = r_out_count;

`ifdef BYTE_WORD_PACKER_PARITY_EN
  logic r_out_parity;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_parity <= 1'b0;
    end else if (w_done) begin
      r_out_parity <= ^w_word;
    end
  end

  assign out_parity = r_out_parity;
`else
  assign out_parity = 1'b0;
`endif

endmodule
